// File: rtl/rv32i_pkg.sv
// Shared definitions for the RV32I memory arbiter: access-size encodings,
// FSM state encoding and the memory bus width.
package rv32i_pkg;

    localparam int BUS_BITS = 16;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'b00,
        SIZE_HALF = 2'b01,
        SIZE_WORD = 2'b10
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_BEAT_LO = 2'b01,
        ST_BEAT_HI = 2'b10,
        ST_RESP    = 2'b11
    } arb_state_e;

    // The unused size code 2'b11 is treated as a word so it never hangs the FSM.
    function automatic logic is_word(input logic [1:0] size);
        return (size != SIZE_BYTE) && (size != SIZE_HALF);
    endfunction

    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lsbs);
        if (size == SIZE_HALF) begin
            return addr_lsbs[0];
        end
        if (is_word(size)) begin
            return addr_lsbs != 2'b00;
        end
        return 1'b0;
    endfunction

endpackage

// File: rtl/rv32i_mem_arbiter_if.sv
// 16-bit memory bus between the arbiter (master) and the memory (slave).
interface rv32i_mem_arbiter_if #(
    parameter int XLEN = 32
);
    import rv32i_pkg::*;

    logic [XLEN-1:0]     mem_addr_o;
    logic [BUS_BITS-1:0] mem_wdata_o;
    logic [BUS_BITS-1:0] mem_rdata_i;
    logic                mem_read_o;
    logic                mem_write_o;
    logic [1:0]          mem_be_o;
    logic                mem_ready_i;

    modport master (
        output mem_addr_o,
        output mem_wdata_o,
        output mem_read_o,
        output mem_write_o,
        output mem_be_o,
        input  mem_rdata_i,
        input  mem_ready_i
    );

    modport slave (
        input  mem_addr_o,
        input  mem_wdata_o,
        input  mem_read_o,
        input  mem_write_o,
        input  mem_be_o,
        output mem_rdata_i,
        output mem_ready_i
    );

endinterface

// File: rtl/rv32i_lane_steer.sv
// Combinational byte-lane steering: byte enables and write replication for the
// outgoing beat, byte extraction for the returning beat.
module rv32i_lane_steer
    import rv32i_pkg::*;
(
    input  logic [1:0]          i_wr_size,
    input  logic                i_wr_addr0,
    input  logic [BUS_BITS-1:0] i_wr_data,
    output logic [1:0]          o_be,
    output logic [BUS_BITS-1:0] o_wr_data,
    input  logic [1:0]          i_rd_size,
    input  logic                i_rd_addr0,
    input  logic [BUS_BITS-1:0] i_rd_data,
    output logic [BUS_BITS-1:0] o_rd_data
);

    // A byte store puts the same byte on both lanes; the enables pick the real one.
    always_comb begin
        o_be      = 2'b11;
        o_wr_data = i_wr_data;
        if (i_wr_size == SIZE_BYTE) begin
            o_be      = i_wr_addr0 ? 2'b10 : 2'b01;
            o_wr_data = {2{i_wr_data[7:0]}};
        end
    end

    always_comb begin
        o_rd_data = i_rd_data;
        if (i_rd_size == SIZE_BYTE) begin
            o_rd_data = {8'h00, (i_rd_addr0 ? i_rd_data[15:8] : i_rd_data[7:0])};
        end
    end

endmodule

// File: rtl/rv32i_mem_arbiter.sv
// Arbitrates an instruction-fetch port and a data port onto one 16-bit memory bus.
// Define RV32I_ARB_FAIR_EN for round-robin arbitration; default is data priority.
module rv32i_mem_arbiter #(
    parameter int XLEN     = 32,
    parameter int BUS_BITS = rv32i_pkg::BUS_BITS
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic                if_req_i,
    input  logic [XLEN-1:0]     if_addr_i,
    output logic [XLEN-1:0]     if_data_o,
    output logic                if_done_o,
    input  logic                d_req_i,
    input  logic                d_we_i,
    input  logic [1:0]          d_size_i,
    input  logic [XLEN-1:0]     d_addr_i,
    input  logic [XLEN-1:0]     d_wdata_i,
    output logic [XLEN-1:0]     d_rdata_o,
    output logic                d_done_o,
    output logic                d_misaligned_o,
    rv32i_mem_arbiter_if.master mem
);
    import rv32i_pkg::*;

    localparam logic [XLEN-1:0] ADDR_ALIGN = ~XLEN'(1);

    arb_state_e          r_state, w_next_state;
    logic                r_is_data, w_next_is_data;
    logic                r_we, w_next_we;
    logic [1:0]          r_size, w_next_size;
    logic                r_addr0, w_next_addr0;
    logic [BUS_BITS-1:0] r_wdata_hi, w_next_wdata_hi;
    logic [BUS_BITS-1:0] r_rdata_lo, w_next_rdata_lo;
    logic [XLEN-1:0]     r_if_data, w_next_if_data;
    logic [XLEN-1:0]     r_d_rdata, w_next_d_rdata;
    logic                r_if_done, w_next_if_done;
    logic                r_d_done, w_next_d_done;
    logic                r_d_mis, w_next_d_mis;
    logic [XLEN-1:0]     r_mem_addr, w_next_mem_addr;
    logic [BUS_BITS-1:0] r_mem_wdata, w_next_mem_wdata;
    logic                r_mem_read, w_next_mem_read;
    logic                r_mem_write, w_next_mem_write;
    logic [1:0]          r_mem_be, w_next_mem_be;

    logic                w_grant_data;
    logic                w_grant_fetch;
    logic [XLEN-1:0]     w_req_addr;
    logic [1:0]          w_req_size;
    logic                w_req_we;
    logic [XLEN-1:0]     w_req_wdata;
    logic                w_req_mis;
    logic [1:0]          w_st_size;
    logic                w_st_addr0;
    logic [BUS_BITS-1:0] w_st_wdata;
    logic [1:0]          w_be;
    logic [BUS_BITS-1:0] w_wdata_lane;
    logic [BUS_BITS-1:0] w_rdata_lane;

`ifdef RV32I_ARB_FAIR_EN
    logic r_last_data;

    assign w_grant_data = d_req_i && (!if_req_i || !r_last_data);

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_last_data <= 1'b0;
        end else if ((r_state == ST_IDLE) && (w_grant_data || w_grant_fetch)) begin
            r_last_data <= w_grant_data;
        end
    end
`else
    assign w_grant_data = d_req_i;
`endif

    assign w_grant_fetch = if_req_i && !w_grant_data;

    // Fetches are always word reads from the halfword-aligned address.
    always_comb begin
        if (w_grant_data) begin
            w_req_addr  = d_addr_i;
            w_req_size  = d_size_i;
            w_req_we    = d_we_i;
            w_req_wdata = d_wdata_i;
        end else begin
            w_req_addr  = if_addr_i & ADDR_ALIGN;
            w_req_size  = SIZE_WORD;
            w_req_we    = 1'b0;
            w_req_wdata = '0;
        end
    end

    assign w_req_mis = w_grant_data && is_misaligned(d_size_i, d_addr_i[1:0]);

    always_comb begin
        if (r_state == ST_IDLE) begin
            w_st_size  = w_req_size;
            w_st_addr0 = w_req_addr[0];
            w_st_wdata = w_req_wdata[BUS_BITS-1:0];
        end else begin
            w_st_size  = r_size;
            w_st_addr0 = r_addr0;
            w_st_wdata = r_wdata_hi;
        end
    end

    rv32i_lane_steer u_lane_steer (
        .i_wr_size  (w_st_size),
        .i_wr_addr0 (w_st_addr0),
        .i_wr_data  (w_st_wdata),
        .o_be       (w_be),
        .o_wr_data  (w_wdata_lane),
        .i_rd_size  (r_size),
        .i_rd_addr0 (r_addr0),
        .i_rd_data  (mem.mem_rdata_i),
        .o_rd_data  (w_rdata_lane)
    );

    // Bus outputs are registered, so each state loads the values the next beat needs.
    always_comb begin
        w_next_state     = r_state;
        w_next_is_data   = r_is_data;
        w_next_we        = r_we;
        w_next_size      = r_size;
        w_next_addr0     = r_addr0;
        w_next_wdata_hi  = r_wdata_hi;
        w_next_rdata_lo  = r_rdata_lo;
        w_next_if_data   = r_if_data;
        w_next_d_rdata   = r_d_rdata;
        w_next_if_done   = 1'b0;
        w_next_d_done    = 1'b0;
        w_next_d_mis     = 1'b0;
        w_next_mem_addr  = r_mem_addr;
        w_next_mem_wdata = r_mem_wdata;
        w_next_mem_read  = r_mem_read;
        w_next_mem_write = r_mem_write;
        w_next_mem_be    = r_mem_be;

        case (r_state)
            ST_IDLE: begin
                if (w_grant_data || w_grant_fetch) begin
                    w_next_is_data  = w_grant_data;
                    w_next_we       = w_req_we;
                    w_next_size     = w_req_size;
                    w_next_addr0    = w_req_addr[0];
                    w_next_wdata_hi = w_req_wdata[2*BUS_BITS-1:BUS_BITS];
                    if (w_req_mis) begin
                        w_next_state  = ST_RESP;
                        w_next_d_done = 1'b1;
                        w_next_d_mis  = 1'b1;
                    end else begin
                        w_next_state     = ST_BEAT_LO;
                        w_next_mem_addr  = w_req_addr & ADDR_ALIGN;
                        w_next_mem_wdata = w_wdata_lane;
                        w_next_mem_be    = w_be;
                        w_next_mem_read  = !w_req_we;
                        w_next_mem_write = w_req_we;
                    end
                end
            end
            ST_BEAT_LO: begin
                if (mem.mem_ready_i) begin
                    if (is_word(r_size)) begin
                        w_next_state     = ST_BEAT_HI;
                        w_next_rdata_lo  = mem.mem_rdata_i;
                        w_next_mem_addr  = r_mem_addr + XLEN'(2);
                        w_next_mem_wdata = w_wdata_lane;
                        w_next_mem_be    = w_be;
                    end else begin
                        w_next_state     = ST_RESP;
                        w_next_mem_read  = 1'b0;
                        w_next_mem_write = 1'b0;
                        w_next_mem_be    = 2'b00;
                        w_next_d_done    = 1'b1;
                        if (!r_we) begin
                            w_next_d_rdata = XLEN'(w_rdata_lane);
                        end
                    end
                end
            end
            ST_BEAT_HI: begin
                if (mem.mem_ready_i) begin
                    w_next_state     = ST_RESP;
                    w_next_mem_read  = 1'b0;
                    w_next_mem_write = 1'b0;
                    w_next_mem_be    = 2'b00;
                    if (r_is_data) begin
                        w_next_d_done = 1'b1;
                        if (!r_we) begin
                            w_next_d_rdata = XLEN'({mem.mem_rdata_i, r_rdata_lo});
                        end
                    end else begin
                        w_next_if_done = 1'b1;
                        w_next_if_data = XLEN'({mem.mem_rdata_i, r_rdata_lo});
                    end
                end
            end
            ST_RESP: begin
                w_next_state = ST_IDLE;
            end
            default: begin
                w_next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state     <= ST_IDLE;
            r_is_data   <= 1'b0;
            r_we        <= 1'b0;
            r_size      <= 2'b00;
            r_addr0     <= 1'b0;
            r_wdata_hi  <= '0;
            r_rdata_lo  <= '0;
            r_if_data   <= '0;
            r_d_rdata   <= '0;
            r_if_done   <= 1'b0;
            r_d_done    <= 1'b0;
            r_d_mis     <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_read  <= 1'b0;
            r_mem_write <= 1'b0;
            r_mem_be    <= 2'b00;
        end else begin
            r_state     <= w_next_state;
            r_is_data   <= w_next_is_data;
            r_we        <= w_next_we;
            r_size      <= w_next_size;
            r_addr0     <= w_next_addr0;
            r_wdata_hi  <= w_next_wdata_hi;
            r_rdata_lo  <= w_next_rdata_lo;
            r_if_data   <= w_next_if_data;
            r_d_rdata   <= w_next_d_rdata;
            r_if_done   <= w_next_if_done;
            r_d_done    <= w_next_d_done;
            r_d_mis     <= w_next_d_mis;
            r_mem_addr  <= w_next_mem_addr;
            r_mem_wdata <= w_next_mem_wdata;
            r_mem_read  <= w_next_mem_read;
            r_mem_write <= w_next_mem_write;
            r_mem_be    <= w_next_mem_be;
        end
    end

    assign if_data_o       = r_if_data;
    assign if_done_o       = r_if_done;
    assign d_rdata_o       = r_d_rdata;
    assign d_done_o        = r_d_done;
    assign d_misaligned_o  = r_d_mis;
    assign mem.mem_addr_o  = r_mem_addr;
    assign mem.mem_wdata_o = r_mem_wdata;
    assign mem.mem_read_o  = r_mem_read;
    assign mem.mem_write_o = r_mem_write;
    assign mem.mem_be_o    = r_mem_be;

endmodule

// File: tb/tb_rv32i_mem_arbiter.sv
// Directed, table-driven bench for rv32i_mem_arbiter plus hand-written
// sequences for arbitration, bus stalls and reset during a transfer.
module tb_rv32i_mem_arbiter;

    localparam int XLEN = 32;

    typedef struct {
        bit          isFetch;
        bit          we;
        logic [1:0]  size;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [15:0] rdLo;
        logic [15:0] rdHi;
        int          expBeats;
        logic [31:0] expAddr0;
        logic [1:0]  expBe;
        logic [15:0] expW0;
        logic [15:0] expW1;
        int          expDone;
        logic [31:0] expRdata;
        bit          expMis;
    } vec_t;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            ifReq = 1'b0;
    logic [XLEN-1:0] ifAddr = '0;
    logic [XLEN-1:0] ifData;
    logic            ifDone;
    logic            dReq = 1'b0;
    logic            dWe = 1'b0;
    logic [1:0]      dSize = 2'b00;
    logic [XLEN-1:0] dAddr = '0;
    logic [XLEN-1:0] dWdata = '0;
    logic [XLEN-1:0] dRdata;
    logic            dDone;
    logic            dMis;

    int checks = 0;
    int failures = 0;

    int          beatCount;
    logic [31:0] beatAddr [4];
    logic [1:0]  beatBe [4];
    logic [15:0] beatWdata [4];
    bit          beatWrite [4];
    logic [15:0] rdData [4];
    int          doneCyc;
    logic        doneIf;
    logic        doneD;
    logic        doneMis;
    logic [31:0] doneIfData;
    logic [31:0] doneDData;

    vec_t vecs [13];

    rv32i_mem_arbiter_if #(.XLEN(XLEN)) bus ();

    rv32i_mem_arbiter #(.XLEN(XLEN), .BUS_BITS(16)) dut (
        .clk_i          (clk),
        .reset_i        (reset),
        .if_req_i       (ifReq),
        .if_addr_i      (ifAddr),
        .if_data_o      (ifData),
        .if_done_o      (ifDone),
        .d_req_i        (dReq),
        .d_we_i         (dWe),
        .d_size_i       (dSize),
        .d_addr_i       (dAddr),
        .d_wdata_i      (dWdata),
        .d_rdata_o      (dRdata),
        .d_done_o       (dDone),
        .d_misaligned_o (dMis),
        .mem            (bus.master)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkValue(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: actual=0x%0h expected=0x%0h", name, actual, expected);
        end
    endtask

    task automatic checkAllZero(input string tag);
        checkValue({tag, "_if_done"}, 32'(ifDone), 32'd0);
        checkValue({tag, "_d_done"}, 32'(dDone), 32'd0);
        checkValue({tag, "_d_mis"}, 32'(dMis), 32'd0);
        checkValue({tag, "_if_data"}, ifData, 32'd0);
        checkValue({tag, "_d_rdata"}, dRdata, 32'd0);
        checkValue({tag, "_mem_addr"}, bus.mem_addr_o, 32'd0);
        checkValue({tag, "_mem_wdata"}, 32'(bus.mem_wdata_o), 32'd0);
        checkValue({tag, "_mem_strobes"}, 32'({bus.mem_read_o, bus.mem_write_o}), 32'd0);
        checkValue({tag, "_mem_be"}, 32'(bus.mem_be_o), 32'd0);
    endtask

    // Steps the clock until a done pulse, acting as memory with ready held high.
    task automatic runUntilDone(input int maxCyc);
        beatCount = 0;
        doneCyc   = -1;
        doneIf    = 1'b0;
        doneD     = 1'b0;
        doneMis   = 1'b0;
        for (int c = 1; c <= maxCyc && doneCyc < 0; c++) begin
            @(posedge clk);
            #1;
            if (bus.mem_read_o || bus.mem_write_o) begin
                checkValue("rw_exclusive", 32'(bus.mem_read_o & bus.mem_write_o), 32'd0);
                if (beatCount < 4) begin
                    beatAddr[beatCount]  = bus.mem_addr_o;
                    beatBe[beatCount]    = bus.mem_be_o;
                    beatWdata[beatCount] = bus.mem_wdata_o;
                    beatWrite[beatCount] = bus.mem_write_o;
                    bus.mem_rdata_i      = rdData[beatCount];
                end
                beatCount++;
            end
            if (ifDone || dDone) begin
                doneCyc    = c;
                doneIf     = ifDone;
                doneD      = dDone;
                doneMis    = dMis;
                doneIfData = ifData;
                doneDData  = dRdata;
            end
        end
        checkValue("done_seen", 32'(doneCyc >= 0), 32'd1);
    endtask

    task automatic applyStimulus(input vec_t v);
        rdData[0] = v.rdLo;
        rdData[1] = v.rdHi;
        @(posedge clk);
        #1;
        if (v.isFetch) begin
            ifReq  = 1'b1;
            ifAddr = v.addr;
        end else begin
            dReq   = 1'b1;
            dWe    = v.we;
            dSize  = v.size;
            dAddr  = v.addr;
            dWdata = v.wdata;
        end
    endtask

    task automatic checkOutput(input vec_t v);
        checkValue("done_cycle", doneCyc, v.expDone);
        checkValue("done_port", 32'({doneIf, doneD}), v.isFetch ? 32'd2 : 32'd1);
        checkValue("beat_count", beatCount, v.expBeats);
        if (!v.isFetch) begin
            checkValue("misaligned", 32'(doneMis), 32'(v.expMis));
        end
        if (v.expBeats >= 1 && beatCount >= 1) begin
            checkValue("beat0_addr", beatAddr[0], v.expAddr0);
            checkValue("beat0_be", 32'(beatBe[0]), 32'(v.expBe));
            checkValue("beat0_kind", 32'(beatWrite[0]), 32'(v.we));
            if (v.we) begin
                checkValue("beat0_wdata", 32'(beatWdata[0]), 32'(v.expW0));
            end
        end
        if (v.expBeats == 2 && beatCount >= 2) begin
            checkValue("beat1_addr", beatAddr[1], v.expAddr0 + 32'd2);
            checkValue("beat1_be", 32'(beatBe[1]), 32'd3);
            if (v.we) begin
                checkValue("beat1_wdata", 32'(beatWdata[1]), 32'(v.expW1));
            end
        end
        if (!v.we && !v.expMis) begin
            checkValue("read_data", v.isFetch ? doneIfData : doneDData, v.expRdata);
        end
    endtask

    initial begin
        vec_t tail;

        //           fetch we  size   addr          wdata         rdLo      rdHi      nb addr0         be     w0        w1        dn rdata          mis
        vecs[0]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0100, 32'h0,        16'h1234, 16'hABCD, 2, 32'h0000_0100, 2'b11, 16'h0,    16'h0,    3, 32'hABCD_1234, 1'b0};
        vecs[1]  = '{1'b1, 1'b0, 2'b10, 32'h0000_0203, 32'h0,        16'h1111, 16'h2222, 2, 32'h0000_0202, 2'b11, 16'h0,    16'h0,    3, 32'h2222_1111, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0203, 32'h1234_56A5, 16'h0,   16'h0,    1, 32'h0000_0202, 2'b10, 16'hA5A5, 16'h0,    2, 32'h0,         1'b0};
        vecs[3]  = '{1'b0, 1'b1, 2'b00, 32'h0000_0200, 32'h0000_003C, 16'h0,   16'h0,    1, 32'h0000_0200, 2'b01, 16'h3C3C, 16'h0,    2, 32'h0,         1'b0};
        vecs[4]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0401, 32'h0,        16'hBEEF, 16'h0,    1, 32'h0000_0400, 2'b10, 16'h0,    16'h0,    2, 32'h0000_00BE, 1'b0};
        vecs[5]  = '{1'b0, 1'b0, 2'b00, 32'h0000_0400, 32'h0,        16'hBEEF, 16'h0,    1, 32'h0000_0400, 2'b01, 16'h0,    16'h0,    2, 32'h0000_00EF, 1'b0};
        vecs[6]  = '{1'b0, 1'b0, 2'b01, 32'h0000_0402, 32'h0,        16'h8001, 16'h0,    1, 32'h0000_0402, 2'b11, 16'h0,    16'h0,    2, 32'h0000_8001, 1'b0};
        vecs[7]  = '{1'b0, 1'b1, 2'b01, 32'h0000_0404, 32'hDEAD_CAFE, 16'h0,   16'h0,    1, 32'h0000_0404, 2'b11, 16'hCAFE, 16'h0,    2, 32'h0,         1'b0};
        vecs[8]  = '{1'b0, 1'b1, 2'b10, 32'h0000_0500, 32'h1234_5678, 16'h0,   16'h0,    2, 32'h0000_0500, 2'b11, 16'h5678, 16'h1234, 3, 32'h0,         1'b0};
        vecs[9]  = '{1'b0, 1'b0, 2'b10, 32'h0000_0600, 32'h0,        16'h4444, 16'h5555, 2, 32'h0000_0600, 2'b11, 16'h0,    16'h0,    3, 32'h5555_4444, 1'b0};
        vecs[10] = '{1'b0, 1'b0, 2'b10, 32'h0000_0302, 32'h0,        16'h0,    16'h0,    0, 32'h0,         2'b00, 16'h0,    16'h0,    1, 32'h0,         1'b1};
        vecs[11] = '{1'b0, 1'b0, 2'b01, 32'h0000_0305, 32'h0,        16'h0,    16'h0,    0, 32'h0,         2'b00, 16'h0,    16'h0,    1, 32'h0,         1'b1};
        vecs[12] = '{1'b0, 1'b1, 2'b10, 32'h0000_0301, 32'hCAFE_F00D, 16'h0,   16'h0,    0, 32'h0,         2'b00, 16'h0,    16'h0,    1, 32'h0,         1'b1};
        tail     = '{1'b0, 1'b0, 2'b00, 32'h0000_0A01, 32'h0,        16'h5A00, 16'h0,    1, 32'h0000_0A00, 2'b10, 16'h0,    16'h0,    2, 32'h0000_005A, 1'b0};

        bus.mem_ready_i = 1'b1;
        bus.mem_rdata_i = 16'h0000;

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkAllZero("reset");
        reset = 1'b0;

        // Simultaneous requests: data first; then a fresh data request races the waiting fetch.
        rdData[0] = 16'h7711;
        rdData[1] = 16'h0770;
        @(posedge clk);
        #1;
        ifReq  = 1'b1;
        ifAddr = 32'h0000_0700;
        dReq   = 1'b1;
        dWe    = 1'b0;
        dSize  = 2'b00;
        dAddr  = 32'h0000_0801;
        runUntilDone(10);
        checkValue("arb1_data_first", 32'({doneIf, doneD}), 32'd1);
        checkValue("arb1_addr", beatAddr[0], 32'h0000_0800);
        checkValue("arb1_rdata", doneDData, 32'h0000_0077);
        dAddr = 32'h0000_0802;
        runUntilDone(10);
`ifdef RV32I_ARB_FAIR_EN
        checkValue("arb2_fetch_turn", 32'({doneIf, doneD}), 32'd2);
        checkValue("arb2_addr", beatAddr[0], 32'h0000_0700);
        checkValue("arb2_rdata", doneIfData, 32'h0770_7711);
        ifReq = 1'b0;
        runUntilDone(10);
        checkValue("arb3_data_last", 32'({doneIf, doneD}), 32'd1);
        checkValue("arb3_addr", beatAddr[0], 32'h0000_0802);
        checkValue("arb3_rdata", doneDData, 32'h0000_0011);
        dReq = 1'b0;
`else
        checkValue("arb2_data_again", 32'({doneIf, doneD}), 32'd1);
        checkValue("arb2_addr", beatAddr[0], 32'h0000_0802);
        checkValue("arb2_rdata", doneDData, 32'h0000_0011);
        dReq = 1'b0;
        runUntilDone(10);
        checkValue("arb3_fetch_last", 32'({doneIf, doneD}), 32'd2);
        checkValue("arb3_addr", beatAddr[0], 32'h0000_0700);
        checkValue("arb3_rdata", doneIfData, 32'h0770_7711);
        ifReq = 1'b0;
`endif

        for (int i = 0; i < 13; i++) begin
            applyStimulus(vecs[i]);
            runUntilDone(10);
            ifReq = 1'b0;
            dReq  = 1'b0;
            checkOutput(vecs[i]);
        end

        // Word load with ready low for three cycles in the high beat; requester inputs change meanwhile.
        @(posedge clk);
        #1;
        dReq  = 1'b1;
        dWe   = 1'b0;
        dSize = 2'b10;
        dAddr = 32'h0000_0900;
        @(posedge clk);
        #1;
        checkValue("stall_lo_addr", bus.mem_addr_o, 32'h0000_0900);
        checkValue("stall_lo_read", 32'(bus.mem_read_o), 32'd1);
        bus.mem_rdata_i = 16'h1111;
        @(posedge clk);
        #1;
        checkValue("stall_hi_addr", bus.mem_addr_o, 32'h0000_0902);
        bus.mem_ready_i = 1'b0;
        bus.mem_rdata_i = 16'h2222;
        dAddr = 32'hFFFF_FFF0;
        dSize = 2'b00;
        for (int k = 0; k < 3; k++) begin
            @(posedge clk);
            #1;
            checkValue("stall_addr", bus.mem_addr_o, 32'h0000_0902);
            checkValue("stall_strobes", 32'({bus.mem_read_o, bus.mem_write_o}), 32'd2);
            checkValue("stall_be", 32'(bus.mem_be_o), 32'd3);
            checkValue("stall_no_done", 32'(dDone), 32'd0);
            if (k == 2) begin
                bus.mem_ready_i = 1'b1;
            end
        end
        @(posedge clk);
        #1;
        checkValue("stall_done", 32'(dDone), 32'd1);
        checkValue("stall_rdata", dRdata, 32'h2222_1111);
        dReq = 1'b0;

        // Reset asserted during the high beat of a fetch.
        @(posedge clk);
        #1;
        ifReq  = 1'b1;
        ifAddr = 32'h0000_0A00;
        @(posedge clk);
        #1;
        bus.mem_rdata_i = 16'h0001;
        @(posedge clk);
        #1;
        checkValue("rst_hi_addr", bus.mem_addr_o, 32'h0000_0A02);
        reset = 1'b1;
        @(posedge clk);
        #1;
        checkAllZero("rst_mid");
        reset = 1'b0;
        ifReq = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(posedge clk);
            #1;
            checkValue("rst_no_done", 32'({ifDone, dDone}), 32'd0);
        end
        applyStimulus(tail);
        runUntilDone(10);
        dReq = 1'b0;
        checkOutput(tail);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/rv32i_mem_arbiter.md
RV32I_MEM_ARBITER -- requirements
Module: rv32i_mem_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, the requester address and data width.
REQ-002 SHALL have parameter BUS_BITS, default 16, the memory bus data width; only 16 is supported.
REQ-003 SHALL have one clock and a synchronous active-high reset: clk_i  in  1  rising-edge clock; reset_i  in  1  synchronous active-high reset.
REQ-004 SHALL have fetch-port signals:
- if_req_i  in  1  fetch request, held until done.
- if_addr_i  in  XLEN  fetch byte address.
- if_data_o  out  XLEN  fetched instruction.
- if_done_o  out  1  one-cycle completion pulse.
REQ-005 SHALL have data-port signals:
- d_req_i  in  1  data request, held until done.
- d_we_i  in  1  1 = store.
- d_size_i  in  2  00 byte, 01 half, 10 word.
- d_addr_i  in  XLEN  data byte address.
- d_wdata_i  in  XLEN  store data.
- d_rdata_o  out  XLEN  zero-extended load data.
- d_done_o  out  1  one-cycle completion pulse.
- d_misaligned_o  out  1  pulses with d_done_o on a misaligned access.
REQ-006 SHALL have memory-bus signals:
- mem_addr_o  out  XLEN  byte address, bit0 = 0.
- mem_wdata_o  out  16  write data.
- mem_rdata_i  in  16  read data.
- mem_read_o  out  1  read strobe.
- mem_write_o  out  1  write strobe.
- mem_be_o  out  2  byte-lane enables.
- mem_ready_i  in  1  current beat accepted or completed.

Function
REQ-007 SHALL implement states IDLE, BEAT_LO, BEAT_HI and RESP.
REQ-008 SHALL grant in IDLE only, latching the winner, its address, size, write enable and write data; a winner's later change of request or inputs SHALL NOT affect the transfer in progress.
REQ-009 SHALL, with both ports requesting, grant the data port; a lone requester is always granted.
REQ-010 SHALL treat fetch as a 32-bit read at {if_addr_i[XLEN-1:1],1'b0}: two beats, low half at addr, high half at addr+2.
REQ-011 SHALL split data accesses into bus beats:
- Word: two beats, addr then addr+2, mem_be_o = 11 on both.
- Half: one beat, mem_be_o = 11.
- Byte: one beat, mem_be_o = addr[0] ? 10 : 01.
- Byte store: the byte is replicated on both lanes of mem_wdata_o.
REQ-012 SHALL drive all bus outputs from registers, holding mem_read_o/mem_write_o and all bus outputs stable while in a BEAT state until mem_ready_i is sampled high; the beat ends on that edge.
REQ-013 SHALL move BEAT_LO->BEAT_HI for word transfers, and BEAT_LO->RESP otherwise, on the ready edge; BEAT_HI SHALL move to RESP on the ready edge.
REQ-014 SHALL, in RESP, assert exactly one of if_done_o/d_done_o for one cycle with valid if_data_o/d_rdata_o; data SHALL be held until the next RESP. RESP SHALL move to IDLE.
REQ-015 SHALL return load data zero-extended: for a byte, the lane selected by addr[0] goes into d_rdata_o[7:0]; for a half, mem_rdata_i goes into [15:0].
REQ-016 SHALL, for a data access that is a half with addr[0]=1 or a word with addr[1:0]!=0, issue no bus beat, go IDLE->RESP, and pulse d_misaligned_o with d_done_o.
REQ-017 SHALL meet these latencies, with the request sampled in IDLE at cycle 0 and mem_ready_i always high:
- Word: strobes in cycles 1-2, done in cycle 3.
- Byte/half: strobe in cycle 1, done in cycle 2.
- Misaligned: done in cycle 1.
REQ-018 SHALL never assert mem_read_o and mem_write_o together.

Reset
REQ-019 SHALL, on reset_i high at a clock edge, enter IDLE and set every output to 0, including mid-transfer; the aborted transfer SHALL produce no done pulse.
REQ-020 SHALL reset the fairness last-grant record to "fetch".

Configuration
REQ-021 SHALL, with RV32I_ARB_FAIR_EN defined, grant round-robin when both ports request: the port not granted last wins.
REQ-022 SHALL, without RV32I_ARB_FAIR_EN, use fixed data priority per REQ-009.

Structure
REQ-023 SHALL place the size encodings (byte/half/word), the FSM state encoding and the BUS_BITS constant in shared package rv32i_pkg.
REQ-024 SHALL implement byte-lane steering (mem_be_o, write replication, read extraction) in a combinational sub-module rv32i_lane_steer.

Verification
REQ-025 Fetch at 0x100, reading 0x1234 then 0xABCD, ready always high -> beats at 0x100 and 0x102, if_data_o = 0xABCD1234, if_done_o in cycle 3.
REQ-026 Byte store 0xA5 to 0x203 -> one write, mem_addr_o = 0x202, mem_be_o = 10, mem_wdata_o = 0xA5A5, d_done_o in cycle 2.
REQ-027 Both ports requesting in the same cycle -> data served first; with RV32I_ARB_FAIR_EN, a second simultaneous pair serves fetch next.
REQ-028 Word load at 0x302 -> no bus strobe, d_done_o and d_misaligned_o high in cycle 1.
REQ-029 mem_ready_i held low 3 cycles during word BEAT_HI -> bus outputs stable throughout, done one cycle after ready rises.
REQ-030 reset_i asserted during BEAT_HI -> next cycle IDLE with all outputs 0, no done pulse; a new request then completes normally.
